// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback stage: default widths, entry layout,
// the architectural zero register and the skid-buffer occupancy states.
package wb_pkg;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ADDR_W = 3;
    localparam int unsigned ZERO_ADDR  = 0;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_ADDR_W-1:0] rd;
        logic                  we;
    } wb_entry_t;

    // Encoding keeps bit0 = main valid, bit1 = skid valid.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_FULL  = 2'b11
    } buf_state_t;
endpackage

// File: rtl/wb_skid_buf.sv
// Two-entry main/skid storage with a registered ready; main is the oldest entry and
// drives the outputs, skid holds one younger entry while the consumer stalls.
module wb_skid_buf
    import wb_pkg::*;
#(
    parameter int unsigned W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         skid_valid,
    output logic [W-1:0] skid_data
);
    buf_state_t   state;
    logic         ready_q;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         accept;
    logic         retire;

    assign in_ready   = ready_q;
    assign out_valid  = (state != BUF_EMPTY);
    assign skid_valid = (state == BUF_FULL);
    assign out_data   = main_q;
    assign skid_data  = skid_q;
    assign accept     = in_valid & ready_q;
    assign retire     = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= BUF_EMPTY;
            ready_q <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush) begin
            state   <= BUF_EMPTY;
            ready_q <= 1'b1;
        end else begin
            unique case (state)
                BUF_EMPTY: begin
                    if (accept) begin
                        main_q <= in_data;
                        state  <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (accept && retire) begin
                        main_q <= in_data;
                    end else if (accept) begin
                        skid_q  <= in_data;
                        state   <= BUF_FULL;
                        ready_q <= 1'b0;
                    end else if (retire) begin
                        state <= BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (retire) begin
                        main_q  <= skid_q;
                        state   <= BUF_ONE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= BUF_EMPTY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: rtl/writeback_stage_param.sv
// Final pipeline stage before the register file: handshaked writeback entry storage,
// forwarding lookup of pending writes for the hazard unit, and a retired-write counter.
module writeback_stage_param
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter bit          ZERO_REG = 1'b1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] mux_ans_dm,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ans_wb,
    output logic [ADDR_W-1:0] rd_wb,
    output logic              we_wb,
    input  logic [ADDR_W-1:0] fwd_rs,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  wb_count
);
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] rd;
        logic              we;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

    entry_t in_entry;
    entry_t main_entry;
    entry_t skid_entry;
    logic   skid_valid;

    // Writes to the hardwired zero register still flow through but never commit.
    always_comb begin
        in_entry.data = mux_ans_dm;
        in_entry.rd   = in_rd;
        in_entry.we   = in_we & ~(ZERO_REG && (in_rd == ADDR_W'(ZERO_ADDR)));
    end

    wb_skid_buf #(
        .W(ENTRY_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (main_entry),
        .skid_valid(skid_valid),
        .skid_data (skid_entry)
    );

    assign ans_wb = main_entry.data;
    assign rd_wb  = main_entry.rd;
    assign we_wb  = out_valid & main_entry.we;

    // Skid is younger than main, so it wins when both target the same register.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (skid_valid && skid_entry.we && (skid_entry.rd == fwd_rs)) begin
            fwd_hit  = 1'b1;
            fwd_data = skid_entry.data;
        end else if (out_valid && main_entry.we && (main_entry.rd == fwd_rs)) begin
            fwd_hit  = 1'b1;
            fwd_data = main_entry.data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_count <= '0;
        end else if (out_ready && we_wb) begin
            wb_count <= wb_count + 1'b1;
        end
    end
endmodule
